// File: rtl/btn_pkg.sv
// Shared types for the button command controller: FSM states, watch field codes
// and the per-button event record.
package btn_pkg;

    typedef enum logic [1:0] {
        SW_STOP,
        SW_RUN,
        WATCH
    } mode_state_e;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        LONG
    } class_state_e;

    localparam logic [1:0] FIELD_SEC  = 2'd0;
    localparam logic [1:0] FIELD_MIN  = 2'd1;
    localparam logic [1:0] FIELD_HOUR = 2'd2;

    typedef struct packed {
        logic short;
        logic long;
        logic rep;
    } btn_evt_t;

    function automatic logic [1:0] next_field(input logic [1:0] field);
        return (field == FIELD_HOUR) ? FIELD_SEC : field + 2'd1;
    endfunction

endpackage

// File: rtl/btn_press_class.sv
// One button press classifier: times a debounced level into short/long/repeat events.
// Repeat events exist only when BTN_REPEAT_EN is defined.
module btn_press_class
    import btn_pkg::*;
#(
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned REPEAT_MS = 200
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     tick,
    input  logic     level,
    output btn_evt_t evt
);

    localparam int unsigned HW = $clog2(LONG_MS) + 1;

    class_state_e  state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    btn_evt_t      evt_q, evt_d;

`ifdef BTN_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_MS) + 1;
    logic [RW-1:0] rep_q, rep_d;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        evt_d   = '0;
`ifdef BTN_REPEAT_EN
        rep_d   = rep_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (level) begin
                    state_d = HELD;
                    hold_d  = '0;
                end
            end
            HELD: begin
                if (!level) begin
                    evt_d.short = 1'b1;
                    state_d     = IDLE;
                end else if (tick && hold_q != HW'(LONG_MS)) begin
                    hold_d = hold_q + HW'(1);
                    if (hold_d == HW'(LONG_MS)) begin
                        evt_d.long = 1'b1;
                        state_d    = LONG;
`ifdef BTN_REPEAT_EN
                        rep_d      = '0;
`endif
                    end
                end
            end
            LONG: begin
                // Release after a long press is silent.
                if (!level) begin
                    state_d = IDLE;
                end
`ifdef BTN_REPEAT_EN
                else if (tick) begin
                    if (rep_q + RW'(1) == RW'(REPEAT_MS)) begin
                        evt_d.rep = 1'b1;
                        rep_d     = '0;
                    end else begin
                        rep_d = rep_q + RW'(1);
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            evt_q   <= '0;
`ifdef BTN_REPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            evt_q   <= evt_d;
`ifdef BTN_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    assign evt = evt_q;

endmodule

// File: rtl/btn_cmd_ctrl.sv
// Button command controller: 1 ms tick divider, three press classifiers and the
// stopwatch/watch mode FSM. Define BTN_REPEAT_EN to enable auto-repeat events.
module btn_cmd_ctrl
    import btn_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100000,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned REPEAT_MS = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_run,
    input  logic       i_clear,
    input  logic       i_mode,
    output logic       o_mode,
    output logic       o_run,
    output logic       o_clear,
    output logic       o_inc,
    output logic [1:0] o_field
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0] div_q;
    logic          tick;
    btn_evt_t      run_evt, clear_evt, mode_evt;

    assign tick = (div_q == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + TW'(1);
        end
    end

    btn_press_class #(.LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS)) u_run (
        .clk(clk), .rst(rst), .tick(tick), .level(i_run), .evt(run_evt)
    );
    btn_press_class #(.LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS)) u_clear (
        .clk(clk), .rst(rst), .tick(tick), .level(i_clear), .evt(clear_evt)
    );
    btn_press_class #(.LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS)) u_mode (
        .clk(clk), .rst(rst), .tick(tick), .level(i_mode), .evt(mode_evt)
    );

    mode_state_e state_q, state_d;
    logic        mode_q, run_q, run_d, clear_q, clear_d, inc_q, inc_d;
    logic [1:0]  field_q, field_d;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        clear_d = 1'b0;
        inc_d   = 1'b0;
        field_d = field_q;
        // Only the highest-priority button with any event acts this cycle.
        if (clear_evt != '0) begin
            if (state_q == WATCH) begin
                if (clear_evt.short) field_d = next_field(field_q);
            end else if (clear_evt.long) begin
                run_d   = 1'b0;
                clear_d = 1'b1;
                state_d = SW_STOP;
            end else if (clear_evt.short && state_q == SW_STOP) begin
                clear_d = 1'b1;
            end
        end else if (mode_evt != '0) begin
            if (mode_evt.short) begin
                if (state_q == WATCH) state_d = run_q ? SW_RUN : SW_STOP;
                else                  state_d = WATCH;
            end
        end else if (run_evt != '0) begin
            unique case (state_q)
                SW_STOP: if (run_evt.short) begin
                    state_d = SW_RUN;
                    run_d   = 1'b1;
                end
                SW_RUN: if (run_evt.short) begin
                    state_d = SW_STOP;
                    run_d   = 1'b0;
                end
                WATCH:   inc_d = 1'b1;
                default: state_d = SW_STOP;
            endcase
        end
        clear_d = clear_d & ~clear_q;
        inc_d   = inc_d & ~inc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SW_STOP;
            mode_q  <= 1'b0;
            run_q   <= 1'b0;
            clear_q <= 1'b0;
            inc_q   <= 1'b0;
            field_q <= FIELD_SEC;
        end else begin
            state_q <= state_d;
            mode_q  <= (state_d == WATCH);
            run_q   <= run_d;
            clear_q <= clear_d;
            inc_q   <= inc_d;
            field_q <= field_d;
        end
    end

    assign o_mode  = mode_q;
    assign o_run   = run_q;
    assign o_clear = clear_q;
    assign o_inc   = inc_q;
    assign o_field = field_q;

endmodule

// File: tb/tb_btn_cmd_ctrl.sv
// Directed bench for btn_cmd_ctrl with TICK_DIV=2, LONG_MS=10, REPEAT_MS=4.
module tb_btn_cmd_ctrl;

`ifdef BTN_REPEAT_EN
    localparam int REP_INC = 4;
`else
    localparam int REP_INC = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       i_run, i_clear, i_mode;
    logic       o_mode, o_run, o_clear, o_inc;
    logic [1:0] o_field;

    always #5 clk = ~clk;

    btn_cmd_ctrl #(.TICK_DIV(2), .LONG_MS(10), .REPEAT_MS(4)) dut (
        .clk(clk), .rst(rst), .i_run(i_run), .i_clear(i_clear), .i_mode(i_mode),
        .o_mode(o_mode), .o_run(o_run), .o_clear(o_clear), .o_inc(o_inc), .o_field(o_field)
    );

    typedef struct {
        int run, clr, mode, hold;
        int e_mode, e_run, e_field, e_clr, e_inc;
    } vec_t;

    vec_t vecs[21];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   clr_cnt = 0;
    int   inc_cnt = 0;
    int   consec  = 0;
    logic prev_clr = 1'b0;
    logic prev_inc = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance n cycles, sampling on the falling edge and counting command pulses.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (o_clear) clr_cnt++;
            if (o_inc) inc_cnt++;
            if ((o_clear && prev_clr) || (o_inc && prev_inc)) consec++;
            prev_clr = o_clear;
            prev_inc = o_inc;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_mode"},  int'(o_mode),  0);
        check({tag, "_run"},   int'(o_run),   0);
        check({tag, "_clear"}, int'(o_clear), 0);
        check({tag, "_inc"},   int'(o_inc),   0);
        check({tag, "_field"}, int'(o_field), 0);
    endtask

    task automatic press(input int r, input int c, input int m, input int hold);
        i_run   = (r != 0);
        i_clear = (c != 0);
        i_mode  = (m != 0);
        step(hold);
        i_run   = 1'b0;
        i_clear = 1'b0;
        i_mode  = 1'b0;
    endtask

    initial begin
        //          run clr mode hold  mode run field clr inc
        vecs[0]  = '{1, 0, 0, 12,  0, 1, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 12,  0, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 0,  6,  0, 0, 0, 1, 0};
        vecs[3]  = '{1, 0, 0, 12,  0, 1, 0, 0, 0};
        vecs[4]  = '{0, 1, 0,  6,  0, 1, 0, 0, 0};
        vecs[5]  = '{0, 1, 0, 24,  0, 0, 0, 1, 0};
        vecs[6]  = '{1, 0, 0, 12,  0, 1, 0, 0, 0};
        vecs[7]  = '{0, 0, 1,  6,  1, 1, 0, 0, 0};
        vecs[8]  = '{0, 1, 0,  6,  1, 1, 1, 0, 0};
        vecs[9]  = '{0, 1, 0,  6,  1, 1, 2, 0, 0};
        vecs[10] = '{0, 1, 0,  6,  1, 1, 0, 0, 0};
        vecs[11] = '{0, 1, 0,  6,  1, 1, 1, 0, 0};
        vecs[12] = '{1, 0, 0, 12,  1, 1, 1, 0, 1};
        vecs[13] = '{1, 0, 0, 46,  1, 1, 1, 0, REP_INC};
        vecs[14] = '{0, 0, 1,  6,  0, 1, 1, 0, 0};
        vecs[15] = '{1, 0, 0, 12,  0, 0, 1, 0, 0};
        vecs[16] = '{1, 1, 0, 12,  0, 0, 1, 1, 0};
        vecs[17] = '{1, 0, 1, 12,  1, 0, 1, 0, 0};
        vecs[18] = '{0, 1, 0, 24,  1, 0, 1, 0, 0};
        vecs[19] = '{0, 0, 1, 24,  1, 0, 1, 0, 0};
        vecs[20] = '{0, 0, 1,  6,  0, 0, 1, 0, 0};

        rst     = 1'b0;
        i_run   = 1'b0;
        i_clear = 1'b0;
        i_mode  = 1'b0;
        step(3);
        rst = 1'b1;
        check_idle("reset");

        // RUN short: o_run rises exactly two cycles after the release.
        press(1, 0, 0, 12);
        step(1);
        check("run_rise_n1", int'(o_run), 0);
        step(1);
        check("run_rise_n2", int'(o_run), 1);

        // CLEAR short in SW_STOP: one-cycle pulse two cycles after release.
        do_reset();
        press(0, 1, 0, 6);
        step(1);
        check("clr_pulse_n1", int'(o_clear), 0);
        step(1);
        check("clr_pulse_n2", int'(o_clear), 1);
        step(1);
        check("clr_pulse_n3", int'(o_clear), 0);
        check("clr_stays_stop", int'(o_run), 0);

        do_reset();
        for (int v = 0; v < 21; v++) begin
            clr_cnt = 0;
            inc_cnt = 0;
            press(vecs[v].run, vecs[v].clr, vecs[v].mode, vecs[v].hold);
            step(8);
            check($sformatf("vec%0d_mode", v),  int'(o_mode),  vecs[v].e_mode);
            check($sformatf("vec%0d_run", v),   int'(o_run),   vecs[v].e_run);
            check($sformatf("vec%0d_field", v), int'(o_field), vecs[v].e_field);
            check($sformatf("vec%0d_clr", v),   clr_cnt,       vecs[v].e_clr);
            check($sformatf("vec%0d_inc", v),   inc_cnt,       vecs[v].e_inc);
        end

        // CLEAR long in SW_RUN acts at the long threshold, silent on release.
        do_reset();
        press(1, 0, 0, 12);
        step(6);
        check("long_pre_run", int'(o_run), 1);
        clr_cnt = 0;
        i_clear = 1'b1;
        step(24);
        check("long_clr_before_release", clr_cnt, 1);
        check("long_run_before_release", int'(o_run), 0);
        i_clear = 1'b0;
        clr_cnt = 0;
        step(8);
        check("long_clr_after_release", clr_cnt, 0);
        check("long_run_after_release", int'(o_run), 0);

        // Reset mid-hold; the still-held RUN becomes a new long press (ignored).
        press(1, 0, 0, 12);
        step(6);
        press(0, 0, 1, 6);
        step(6);
        check("rmh_pre_mode", int'(o_mode), 1);
        i_run = 1'b1;
        step(6);
        do_reset();
        check_idle("rmh");
        clr_cnt = 0;
        inc_cnt = 0;
        step(24);
        i_run = 1'b0;
        step(8);
        check("rmh_run_after_release", int'(o_run), 0);
        check("rmh_mode_after_release", int'(o_mode), 0);
        check("rmh_clr_after_release", clr_cnt, 0);
        check("rmh_inc_after_release", inc_cnt, 0);

        check("no_back_to_back_pulses", consec, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
